// File: rtl/cdc_word_settle.sv
// Settles a freshly synchronised multi-bit word: a value is committed only after it has
// held unchanged for STABLE_CYCLES samples, then published as a level and as one stream beat.
module cdc_word_settle #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  dropped
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_SETTLING
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_prev;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic [DATA_WIDTH-1:0] r_pend;
    logic                  r_pend_full;
    logic                  r_dropped;

    logic w_change;
    logic w_commit;
    logic w_beat;
    logic w_xfer;
    logic w_free;

    assign w_change = (in_data != r_prev);
    assign w_commit = (r_state == S_SETTLING) && !w_change && (r_cnt == CNT_LAST);
    // A commit that lands on the already-published word (glitch returning home) is silent.
    assign w_beat   = w_commit && (in_data != r_out_data);
    assign w_xfer   = r_tvalid && m_axis_tready;
    assign w_free   = !r_tvalid || w_xfer;

    // Settle FSM: any change restarts the stability count from zero.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_prev     <= '0;
            r_out_data <= '0;
        end else begin
            r_prev <= in_data;
            if (w_change) begin
                r_state <= S_SETTLING;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                    end
                    S_SETTLING: begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            if (w_beat) begin
                                r_out_data <= in_data;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Output register plus one pending slot; the pending slot keeps only the latest word.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_dropped   <= 1'b0;
        end else if (w_beat) begin
            if (w_free && !r_pend_full) begin
                r_tdata  <= in_data;
                r_tvalid <= 1'b1;
            end else if (w_free) begin
                r_tdata  <= r_pend;
                r_tvalid <= 1'b1;
                r_pend   <= in_data;
            end else if (!r_pend_full) begin
                r_pend      <= in_data;
                r_pend_full <= 1'b1;
            end else begin
                r_pend    <= in_data;
                r_dropped <= 1'b1;
            end
        end else if (w_xfer) begin
            if (r_pend_full) begin
                r_tdata     <= r_pend;
                r_pend_full <= 1'b0;
            end else begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign out_data      = r_out_data;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign dropped       = r_dropped;

endmodule

// File: tb/tb_cdc_word_settle.sv
// Directed bench for cdc_word_settle: expected beats go into a queue as stimulus is driven
// and are popped by a handshake monitor; levels are checked at fixed points after edges.
module tb_cdc_word_settle;

    localparam int unsigned DW = 32;

    logic          aclk;
    logic          areset;
    logic [DW-1:0] in_data;
    logic [DW-1:0] out_data;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          dropped;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    cdc_word_settle #(.DATA_WIDTH(DW), .STABLE_CYCLES(4)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .in_data       (in_data),
        .out_data      (out_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .dropped       (dropped)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_tdata"}, m_axis_tdata, '0);
        chk({tag, "_tvalid"}, DW'(m_axis_tvalid), '0);
        chk({tag, "_dropped"}, DW'(dropped), '0);
    endtask

    // Inputs only change 1 time unit after a rising edge, so a handshake seen here is the one
    // the next rising edge will complete.
    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL beat_unexpected observed=%h expected=none", m_axis_tdata);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                assert (m_axis_tdata === e) else begin
                    bad++;
                    $error("FAIL beat_data observed=%h expected=%h", m_axis_tdata, e);
                end
            end
        end
    end

    initial begin
        areset        = 1'b1;
        in_data       = '0;
        m_axis_tready = 1'b1;
        tick(2);
        chk_reset_vals("reset");
        areset = 1'b0;

        // Zero held after reset: nothing to commit.
        tick(10);
        chk_reset_vals("idle_zero");

        // Single change: committed on the 5th edge after the first sample.
        in_data = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        tick(4);
        chk("lat_before", out_data, '0);
        chk("lat_tvalid_before", DW'(m_axis_tvalid), '0);
        tick(1);
        chk("lat_out", out_data, 32'h1234_5678);
        chk("lat_tvalid", DW'(m_axis_tvalid), 1);
        chk("lat_tdata", m_axis_tdata, 32'h1234_5678);
        tick(1);
        chk("lat_tvalid_after", DW'(m_axis_tvalid), '0);

        // Glitch of 3, then exactly 4 cycles, returning home: no commit.
        in_data = 32'h0000_FFFF;
        tick(3);
        in_data = 32'h1234_5678;
        tick(8);
        in_data = 32'h0000_FFFF;
        tick(4);
        in_data = 32'h1234_5678;
        tick(8);
        chk("glitch_out", out_data, 32'h1234_5678);
        chk("glitch_tvalid", DW'(m_axis_tvalid), '0);

        // Flicker every 2 cycles, then settle at 0xAA.
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h0000_FFFF;
            tick(2);
            in_data = 32'h0000_00FF;
            tick(2);
        end
        chk("flicker_out", out_data, 32'h1234_5678);
        in_data = 32'h0000_00AA;
        exp_q.push_back(32'h0000_00AA);
        tick(5);
        chk("flicker_settled", out_data, 32'h0000_00AA);
        tick(3);

        // Backpressure: 1 held in the output register, 2 overwritten by 3 in pending.
        m_axis_tready = 1'b0;
        in_data = 32'h1;
        exp_q.push_back(32'h1);
        tick(5);
        chk("bp_tdata1", m_axis_tdata, 32'h1);
        in_data = 32'h2;
        tick(5);
        chk("bp_hold2", m_axis_tdata, 32'h1);
        chk("bp_drop_before", DW'(dropped), '0);
        in_data = 32'h3;
        exp_q.push_back(32'h3);
        tick(5);
        chk("bp_hold3", m_axis_tdata, 32'h1);
        chk("bp_tvalid", DW'(m_axis_tvalid), 1);
        chk("bp_dropped", DW'(dropped), 1);
        chk("bp_out", out_data, 32'h3);
        m_axis_tready = 1'b1;
        tick(1);
        chk("bp_drain_tdata", m_axis_tdata, 32'h3);
        chk("bp_drain_tvalid", DW'(m_axis_tvalid), 1);
        tick(1);
        chk("bp_drain_done", DW'(m_axis_tvalid), '0);
        chk("bp_dropped_sticky", DW'(dropped), 1);

        // Reset clears the sticky flag.
        in_data = '0;
        areset  = 1'b1;
        tick(1);
        chk_reset_vals("reset2");
        areset = 1'b0;

        // Commit lands on the same edge the previous beat transfers.
        m_axis_tready = 1'b0;
        in_data = 32'h10;
        exp_q.push_back(32'h10);
        tick(5);
        chk("coin_first", m_axis_tdata, 32'h10);
        in_data = 32'h20;
        exp_q.push_back(32'h20);
        tick(4);
        m_axis_tready = 1'b1;
        tick(1);
        chk("coin_tdata", m_axis_tdata, 32'h20);
        chk("coin_tvalid", DW'(m_axis_tvalid), 1);
        chk("coin_dropped", DW'(dropped), '0);
        tick(1);
        chk("coin_done", DW'(m_axis_tvalid), '0);

        // Reset mid-settle: the in-flight word never appears.
        in_data = 32'h55;
        tick(2);
        in_data = '0;
        areset  = 1'b1;
        tick(1);
        chk_reset_vals("rst_settle");
        areset = 1'b0;
        tick(8);
        chk_reset_vals("rst_settle_after");

        // Reset while stalled with pending full: nothing queued may be emitted.
        m_axis_tready = 1'b0;
        in_data = 32'h1;
        tick(5);
        in_data = 32'h2;
        tick(5);
        in_data = 32'h3;
        tick(5);
        chk("stall_dropped", DW'(dropped), 1);
        in_data = '0;
        areset  = 1'b1;
        tick(1);
        chk_reset_vals("rst_stall");
        areset        = 1'b0;
        m_axis_tready = 1'b1;
        tick(10);
        chk_reset_vals("rst_stall_after");

        chk("queue_empty", DW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
